// File: rtl/mdio_capture_reader.sv
// ============================================================================
// Module   : mdio_capture_reader
// Purpose  : MDIO-side readback engine for the ADC capture memories. Accepts
//            register-file read requests, issues a one-cycle chip enable and
//            address to exactly one capture memory, waits RD_LAT cycles, and
//            returns one lane of the addressed word with a valid strobe.
//            Tracks busy, overrun, out-of-range and end-of-buffer status.
// Optional : `define MDIO_RD_AUTOINC_EN adds an internal {sel, addr} pointer
//            with load and auto-increment for sweeping a capture buffer.
// Ports    : clk, rstn (async active-low)
//            rd_en, rd_req, rd_load, rd_sel, rd_addr, auto_inc, last_sel
//            mem_din (flattened read data), mem_cen (one-hot), mem_addr
//            rd_data, rd_valid, busy, rd_done, rd_ovf, rd_err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdio_capture_reader #(
  parameter int NUM_MEM = 24,
  parameter int LANES   = 4,
  parameter int LANE_W  = 9,
  parameter int ADDR_W  = 15,
  parameter int RD_LAT  = 1,
  localparam int SEL_W  = $clog2(NUM_MEM * LANES)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             rd_en,
  input  logic                             rd_req,
  input  logic                             rd_load,
  input  logic [SEL_W-1:0]                 rd_sel,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             auto_inc,
  input  logic [SEL_W-1:0]                 last_sel,
  input  logic [NUM_MEM*LANES*LANE_W-1:0]  mem_din,
  output logic [NUM_MEM-1:0]               mem_cen,
  output logic [NUM_MEM*ADDR_W-1:0]        mem_addr,
  output logic [LANE_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic                             busy,
  output logic                             rd_done,
  output logic                             rd_ovf,
  output logic                             rd_err
);

  localparam int         NUM_LANES = NUM_MEM * LANES;
  // WAIT is left once the counter (started at 1 in ISSUE) reaches RD_LAT-1.
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          wait_cnt;
  logic [SEL_W-1:0]    req_sel;
  logic [ADDR_W-1:0]   req_addr;
  logic [SEL_W-1:0]    cur_mem;
  logic [LANE_W-1:0]   lane_data;
  logic                idle;
  logic                req_ok;
  logic                req_bad;
  logic                req_drop;

  assign idle     = (state == S_IDLE);
  assign busy     = !idle;
  assign req_ok   = rd_en && rd_req && idle && (req_sel <= last_sel);
  assign req_bad  = rd_en && rd_req && idle && (req_sel >  last_sel);
  assign req_drop = rd_en && rd_req && !idle;

`ifdef MDIO_RD_AUTOINC_EN
  logic [SEL_W-1:0]  ptr_sel,  base_sel,  nxt_sel;
  logic [ADDR_W-1:0] ptr_addr, base_addr, nxt_addr;

  // A load in the same cycle as a request is seen by that request.
  assign base_sel  = rd_load ? rd_sel  : ptr_sel;
  assign base_addr = rd_load ? rd_addr : ptr_addr;
  assign req_sel   = auto_inc ? base_sel  : rd_sel;
  assign req_addr  = auto_inc ? base_addr : rd_addr;

  always_comb begin
    nxt_addr = base_addr + 1'b1;
    nxt_sel  = base_sel;
    if (&base_addr) begin
      nxt_sel = (base_sel >= last_sel) ? '0 : base_sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_sel  <= '0;
      ptr_addr <= '0;
    end else if (!rd_en) begin
      ptr_sel  <= '0;
      ptr_addr <= '0;
    end else if (req_ok && auto_inc) begin
      ptr_sel  <= nxt_sel;
      ptr_addr <= nxt_addr;
    end else if (rd_load) begin
      ptr_sel  <= rd_sel;
      ptr_addr <= rd_addr;
    end
  end
`else
  logic unused_autoinc;
  assign unused_autoinc = &{1'b0, rd_load, auto_inc};
  assign req_sel        = rd_sel;
  assign req_addr       = rd_addr;
`endif

  // Global lane select maps straight onto the flattened lane index.
  assign cur_mem   = sel_q / SEL_W'(LANES);
  assign lane_data = (int'(sel_q) < NUM_LANES) ? mem_din[sel_q*LANE_W +: LANE_W] : '0;

  for (genvar m = 0; m < NUM_MEM; m++) begin : g_mem
    logic hit;
    assign hit                          = (state == S_ISSUE) && (cur_mem == SEL_W'(m));
    assign mem_cen[m]                   = hit;
    assign mem_addr[m*ADDR_W +: ADDR_W] = hit ? addr_q : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_ok) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (RD_LAT == 1) ? S_CAPT : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (!rd_en) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q    <= '0;
      addr_q   <= '0;
      wait_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else if (!rd_en) begin
      sel_q    <= '0;
      addr_q   <= '0;
      wait_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (req_ok) begin
        sel_q  <= req_sel;
        addr_q <= req_addr;
      end
      if (state == S_ISSUE)     wait_cnt <= 3'd1;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
      rd_valid <= (state == S_CAPT);
      if (state == S_CAPT) begin
        rd_data <= lane_data;
        if ((sel_q == last_sel) && (&addr_q)) rd_done <= 1'b1;
      end
      if (req_bad)  rd_err <= 1'b1;
      if (req_drop) rd_ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdio_capture_reader.sv
// ============================================================================
// Module   : tb_mdio_capture_reader
// Purpose  : Directed self-checking bench. Two instances (RD_LAT=1 and
//            RD_LAT=3) share all inputs. Lane k of mem_din holds 9'h100+k.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdio_capture_reader;

  localparam int NM = 24;
  localparam int LN = 4;
  localparam int LW = 9;
  localparam int AW = 15;
  localparam int SW = 7;

  logic              clk = 1'b0;
  logic              rstn;
  logic              rd_en, rd_req, rd_load, auto_inc;
  logic [SW-1:0]     rd_sel, last_sel;
  logic [AW-1:0]     rd_addr;
  logic [NM*LN*LW-1:0] mem_din;

  logic [NM-1:0]     cen_1, cen_3;
  logic [NM*AW-1:0]  maddr_1, maddr_3;
  logic [LW-1:0]     data_1, data_3;
  logic              valid_1, busy_1, done_1, ovf_1, err_1;
  logic              valid_3, busy_3, done_3, ovf_3, err_3;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdio_capture_reader #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_req(rd_req), .rd_load(rd_load),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .auto_inc(auto_inc), .last_sel(last_sel),
    .mem_din(mem_din), .mem_cen(cen_1), .mem_addr(maddr_1), .rd_data(data_1),
    .rd_valid(valid_1), .busy(busy_1), .rd_done(done_1), .rd_ovf(ovf_1), .rd_err(err_1)
  );

  mdio_capture_reader #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_req(rd_req), .rd_load(rd_load),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .auto_inc(auto_inc), .last_sel(last_sel),
    .mem_din(mem_din), .mem_cen(cen_3), .mem_addr(maddr_3), .rd_data(data_3),
    .rd_valid(valid_3), .busy(busy_3), .rd_done(done_3), .rd_ovf(ovf_3), .rd_err(err_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NM*AW-1:0] addr_vec(input int m, input logic [AW-1:0] a);
    logic [NM*AW-1:0] v;
    v = '0;
    v[m*AW +: AW] = a;
    return v;
  endfunction

  initial begin
    rstn = 1'b0; rd_en = 1'b0; rd_req = 1'b0; rd_load = 1'b0; auto_inc = 1'b0;
    rd_sel = '0; rd_addr = '0; last_sel = 7'd47;
    for (int k = 0; k < NM*LN; k++) mem_din[k*LW +: LW] = 9'(9'h100 + k);

    // Reset state
    repeat (2) tick();
    check("rst_cen1",   cen_1,   0);
    check("rst_addr1",  maddr_1, 0);
    check("rst_data1",  data_1,  0);
    check("rst_flags1", {valid_1, busy_1, done_1, ovf_1, err_1}, 0);
    check("rst_flags3", {valid_3, busy_3, done_3, ovf_3, err_3}, 0);
    rstn = 1'b1; rd_en = 1'b1;
    tick();

    // Basic read sel=5 (mem 1, lane 1) addr=0x123
    rd_req = 1'b1; rd_sel = 7'd5; rd_addr = 15'h123;
    tick();                                   // T+1
    rd_req = 1'b0;
    check("t1_cen1",   cen_1,   24'h000002);
    check("t1_addr1",  maddr_1, addr_vec(1, 15'h123));
    check("t1_busy1",  busy_1,  1);
    check("t1_cen3",   cen_3,   24'h000002);
    tick();                                   // T+2
    check("t2_cen1",   cen_1,   0);
    check("t2_addr1",  maddr_1, 0);
    check("t2_v1",     {valid_1, busy_1}, 2'b01);
    tick();                                   // T+3
    check("t3_v1",     {valid_1, busy_1}, 2'b10);
    check("t3_data1",  data_1,  9'h105);
    check("t3_v3",     {valid_3, busy_3}, 2'b01);
    tick();                                   // T+4
    check("t4_v",      {valid_1, valid_3}, 2'b00);
    check("t4_data1",  data_1,  9'h105);
    tick();                                   // T+5
    check("t5_v3",     {valid_3, busy_3, done_3}, 3'b100);
    check("t5_data3",  data_3,  9'h105);
    tick();

    // Request while busy is dropped and sets overrun
    rd_req = 1'b1; rd_sel = 7'd10; rd_addr = 15'h044;
    tick();                                   // U+1
    rd_req = 1'b0;
    tick();                                   // U+2
    check("ovf_pre3",  ovf_3, 0);
    rd_req = 1'b1; rd_sel = 7'd20;
    tick();                                   // U+3
    rd_req = 1'b0;
    check("ovf3",      ovf_3, 1);
    check("ovf1",      ovf_1, 1);
    check("ovf_v1",    {valid_1, data_1}, {1'b1, 9'h10A});
    tick();                                   // U+4
    check("ovf_u4",    {valid_1, valid_3, busy_3}, 3'b001);
    tick();                                   // U+5
    check("ovf_v3",    {valid_3, data_3}, {1'b1, 9'h10A});
    tick();                                   // U+6
    check("ovf_u6",    {valid_3, busy_3, ovf_3}, 3'b001);
    rd_en = 1'b0;
    tick();
    check("clr_ovf",   {ovf_1, ovf_3, data_1, data_3}, 0);
    rd_en = 1'b1;
    tick();

    // Out-of-range select
    rd_req = 1'b1; rd_sel = 7'd60; rd_addr = 15'h0;
    tick();                                   // T+1
    rd_req = 1'b0;
    check("err_flags", {err_1, err_3, busy_1, busy_3}, 4'b1100);
    check("err_cen",   {cen_1, cen_3}, 0);
    repeat (2) tick();                        // T+3
    check("err_nov1",  valid_1, 0);
    repeat (2) tick();                        // T+5
    check("err_nov3",  valid_3, 0);

    // Last lane, last address sets done
    rd_req = 1'b1; rd_sel = 7'd47; rd_addr = 15'h7FFF;
    tick();                                   // T+1
    rd_req = 1'b0;
    check("done_cen1", cen_1,   24'h000800);
    check("done_addr1", maddr_1, addr_vec(11, 15'h7FFF));
    tick();                                   // T+2
    check("done_pre1", done_1,  0);
    tick();                                   // T+3
    check("done_v1",   {valid_1, done_1, err_1, data_1}, {3'b111, 9'h12F});
    repeat (2) tick();                        // T+5
    check("done_v3",   {valid_3, done_3, data_3}, {2'b11, 9'h12F});
    rd_en = 1'b0;
    tick();
    check("dis_1",     {valid_1, busy_1, done_1, ovf_1, err_1, data_1}, 0);
    check("dis_3",     {valid_3, busy_3, done_3, ovf_3, err_3, data_3}, 0);
    rd_en = 1'b1;
    tick();

    // Abort during WAIT, then a normal read
    last_sel = 7'd95;
    rd_req = 1'b1; rd_sel = 7'd90; rd_addr = 15'h0001;
    tick();                                   // T+1
    rd_req = 1'b0;
    tick();                                   // T+2
    rd_en = 1'b0;
    tick();                                   // T+3
    check("abort_busy", {busy_1, busy_3, valid_1}, 3'b000);
    rd_en = 1'b1;
    tick();                                   // T+4
    check("abort_nv4", valid_3, 0);
    tick();                                   // T+5
    check("abort_nv5", valid_3, 0);
    rd_req = 1'b1;
    tick();                                   // V+1
    rd_req = 1'b0;
    check("re_cen3",   cen_3,   24'h400000);
    check("re_addr3",  maddr_3, addr_vec(22, 15'h0001));
    repeat (4) tick();                        // V+5
    check("re_v3",     {valid_3, data_3}, {1'b1, 9'h15A});

`ifdef MDIO_RD_AUTOINC_EN
    begin
      logic [AW-1:0] ea [3];
      logic [LW-1:0] ed [3];
      ea = '{15'h7FFE, 15'h7FFF, 15'h0000};
      ed = '{9'h102,   9'h102,   9'h103};
      tick();
      auto_inc = 1'b1; rd_load = 1'b1; rd_sel = 7'd2; rd_addr = 15'h7FFE;
      tick();
      rd_load = 1'b0; rd_sel = 7'd50; rd_addr = 15'h0011;
      for (int i = 0; i < 3; i++) begin
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("ai_cen1",  cen_1,   24'h000001);
        check("ai_addr1", maddr_1, addr_vec(0, ea[i]));
        repeat (2) tick();
        check("ai_data1", {valid_1, data_1}, {1'b1, ed[i]});
        repeat (2) tick();
      end
      auto_inc = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

`default_nettype wire
